c_unary_len: RTL
================

# c_unary_len

Registered downstream stage of the `c_cell` unary-checker chain. It accepts one W-bit candidate vector per transfer, together with the per-position `o_is_unary` and final `o_all_set` outputs of the cell chain. It converts the vector to a binary run length with a validity flag, behind a valid/ready handshake and a 2-entry output buffer. It also keeps saturating accept/reject statistics.

## Interface
- `P_W`, default 8: vector width, minimum 2.
- `P_IS_COMPLIMENT`, default 0: polarity of the code. Must match the cell chain. 0 means a run of ones followed by zeros; 1 means the inverse.
- `P_CNT_W`, default 16: width of the statistics counters.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `i_vld` in 1: input transfer valid.
- `o_rdy` out 1: input ready.
- `i_x` in P_W: candidate vector. Index 0 is the first cell.
- `i_is_unary` in P_W: per-position `o_is_unary` from the cell chain.
- `i_all_set` in 1: `o_all_set` of the last cell, meaning every bit holds the terminal value.
- `o_vld` out 1: result valid.
- `i_rdy` in 1: downstream ready.
- `o_len` out $clog2(P_W+1): run length, range 0..P_W.
- `o_ok` out 1: 1 means the vector is a legal unary code; 0 means it was rejected.
- `o_ok_cnt` out P_CNT_W: number of accepted results, saturating.
- `o_err_cnt` out P_CNT_W: number of rejected results, saturating.
- `i_clr_cnt` in 1: synchronous clear of both counters.

## Operation
- An input transfer occurs when `i_vld & o_rdy`. An output transfer occurs when `o_vld & i_rdy`.
- Each accepted input is classified combinationally.
  - `i_all_set` = 1: `len` = 0, `ok` = 1.
  - Every bit of `i_x` equals the admit value (1, or 0 when `P_IS_COMPLIMENT` = 1): `len` = P_W, `ok` = 1.
  - Otherwise, find k, the lowest index with `i_is_unary[k]` = 1. If k exists: `len` = k, `ok` = 1.
  - Otherwise: `len` = 0, `ok` = 0.
  - The priority order is all_set, then all-admit, then encoder.
- The classified result `{len, ok}` is written into a 2-entry FIFO. The head entry drives `o_len`/`o_ok`.
- FIFO pointers are 1 bit each, with a separate 2-bit occupancy count (0..2).
- `o_rdy` = (occupancy < 2) | (occupancy == 2 & `i_rdy`). Accepting on a full FIFO is allowed only when the head is popped in the same cycle.
- Simultaneous push and pop leaves occupancy unchanged and advances both pointers, including at occupancy 1 and 2.
- Counters update on output transfer, not input. Each pop increments `o_ok_cnt` if `ok` = 1, else `o_err_cnt`. Both counters saturate at all-ones.
- `i_clr_cnt` zeroes both counters and takes priority over an increment in the same cycle. The FIFO is unaffected.
- Data in a FIFO entry is held stable while `o_vld` = 1 and `i_rdy` = 0.
- No FSM beyond the occupancy states EMPTY (0), ONE (1) and FULL (2):
  - EMPTY→ONE on push.
  - ONE→FULL on push without pop.
  - ONE→EMPTY on pop without push.
  - FULL→ONE on pop without push.
  - Any other combination holds the current state.
- `rst` has priority over all other activity. Reset mid-operation discards any buffered results without counting them.

## Timing
- Reset values: `o_vld` = 0, `o_rdy` = 1, `o_len` = 0, `o_ok` = 0, both counters 0, occupancy 0, pointers 0.
- Latency is 1 cycle: an input accepted in cycle n appears at `o_vld`/`o_len` in cycle n+1 when the FIFO was empty.
- Throughput is 1 result per cycle with `i_rdy` held high.
- `o_rdy` depends combinationally on `i_rdy` only in the FULL state. `o_vld`, `o_len`, `o_ok` and the counters come directly from flops.
- Counter values reflect a pop in cycle n from cycle n+1.

## Structure
- Shared package `c_pkg`:
  - `c_len_t` type, sized by P_W.
  - Result struct `c_result_t` {len, ok}.
  - Function `c_admit_value(P_IS_COMPLIMENT)`.
- One sub-module, `c_lsb_enc`: parameterised lowest-set-bit priority encoder producing {found, index}. Reuse it for any future first-edge search.
- FIFO storage and counters are inline.

## Test plan
- P_W = 8, P_IS_COMPLIMENT = 0, `i_x` = 8'b0000_0111 (bits 0..2 set), matching `i_is_unary` = 8'b1111_1000, `i_rdy` = 1 → next cycle `o_vld` = 1, `o_len` = 3, `o_ok` = 1, then `o_ok_cnt` = 1.
- `i_x` = 8'hFF → `o_len` = 8, `o_ok` = 1. `i_x` = 8'h00 with `i_all_set` = 1 → `o_len` = 0, `o_ok` = 1.
- `i_x` = 8'b0000_0101, `i_is_unary` = 0 → `o_ok` = 0, `o_len` = 0, `o_err_cnt` increments by 1.
- Backpressure: hold `i_rdy` = 0 and drive 3 back-to-back valid inputs → first 2 accepted, `o_rdy` = 0 on the third. Release `i_rdy` → results emerge in order, the third is accepted in the pop cycle, no loss or duplication.
- Saturation and clear: P_CNT_W = 2, pop 5 errors → `o_err_cnt` = 3. Assert `i_clr_cnt` in the same cycle as a pop → both counters read 0.
- Reset mid-operation: FIFO FULL, assert `rst` for 1 cycle → `o_vld` = 0, `o_rdy` = 1, counters 0. The next input appears 1 cycle after acceptance.

Source files
------------

// File: rtl/c_unary_len_pkg.sv
// ---------------------------------------------------------------------------
// c_pkg
// Shared types and helpers for the c_cell unary-checker chain and its
// downstream stages.
//   C_DEF_W         : vector width the shared result types are sized for
//   c_len_t         : run-length type, range 0..C_DEF_W
//   c_result_t      : classified result {len, ok}
//   c_len_w()       : run-length width for an arbitrary vector width
//   c_admit_value() : bit value that extends a run for a given polarity
// ---------------------------------------------------------------------------
package c_pkg;

  localparam int C_DEF_W = 8;

  typedef logic [$clog2(C_DEF_W+1)-1:0] c_len_t;

  typedef struct packed {
    c_len_t len;
    logic   ok;
  } c_result_t;

  // Width needed to hold a run length 0..w.
  function automatic int c_len_w(input int w);
    return $clog2(w + 1);
  endfunction

  // Polarity 0: runs are ones followed by zeros. Polarity 1: the inverse.
  function automatic logic c_admit_value(input int is_compliment);
    return (is_compliment == 0) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/c_unary_len_lsb_enc.sv
// ---------------------------------------------------------------------------
// c_lsb_enc
// Lowest-set-bit priority encoder. Reusable for any first-edge search.
// Ports:
//   i_vec   [P_W]         : input vector, index 0 has highest priority
//   o_found               : 1 when any bit of i_vec is set
//   o_idx   [clog2(P_W)]  : index of the lowest set bit (0 when none)
// ---------------------------------------------------------------------------
module c_lsb_enc #(
  parameter int P_W   = 8,
  parameter int IDX_W = (P_W > 1) ? $clog2(P_W) : 1
) (
  input  logic [P_W-1:0]   i_vec,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = P_W - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_found = 1'b1;
        o_idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/c_unary_len.sv
// ---------------------------------------------------------------------------
// c_unary_len
// Registered downstream stage of the c_cell unary-checker chain. Classifies
// each accepted candidate vector into a binary run length plus a legality
// flag, buffers results in a 2-entry FIFO and keeps saturating counts of
// accepted/rejected results as they leave.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its data stable until ready;
// valid never depends on ready. Here input transfer = i_vld & o_rdy, output
// transfer = o_vld & i_rdy. o_rdy looks at i_rdy only when the FIFO is full,
// letting a push land in the slot freed by a same-cycle pop.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   i_vld / o_rdy : input handshake
//   i_x           : candidate vector, index 0 is the first cell
//   i_is_unary    : per-position o_is_unary from the cell chain
//   i_all_set     : o_all_set of the last cell
//   o_vld / i_rdy : output handshake
//   o_len, o_ok   : head result (run length, legal flag)
//   o_ok_cnt      : saturating count of popped legal results
//   o_err_cnt     : saturating count of popped rejected results
//   i_clr_cnt     : synchronous clear of both counters
//   o_dbg_occ     : FIFO occupancy state (EMPTY/ONE/FULL) for observation
// ---------------------------------------------------------------------------
module c_unary_len
  import c_pkg::*;
#(
  parameter int P_W             = 8,
  parameter int P_IS_COMPLIMENT = 0,
  parameter int P_CNT_W         = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_vld,
  output logic                         o_rdy,
  input  logic [P_W-1:0]               i_x,
  input  logic [P_W-1:0]               i_is_unary,
  input  logic                         i_all_set,
  output logic                         o_vld,
  input  logic                         i_rdy,
  output logic [$clog2(P_W+1)-1:0]     o_len,
  output logic                         o_ok,
  output logic [P_CNT_W-1:0]           o_ok_cnt,
  output logic [P_CNT_W-1:0]           o_err_cnt,
  input  logic                         i_clr_cnt,
  output logic [1:0]                   o_dbg_occ
);

  localparam int   LEN_W = c_len_w(P_W);
  localparam int   IDX_W = $clog2(P_W);
  localparam logic ADMIT = c_admit_value(P_IS_COMPLIMENT);

  // Occupancy states of the output buffer.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  // Same layout as c_result_t, sized for this instance's P_W.
  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic             ok;
  } res_t;

  logic             w_found;
  logic [IDX_W-1:0] w_idx;
  res_t             w_res;
  logic             w_push;
  logic             w_pop;

  res_t             r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_occ;
  logic [P_CNT_W-1:0] r_ok_cnt;
  logic [P_CNT_W-1:0] r_err_cnt;

  // -------------------------------------------------------------------------
  // Classification
  // -------------------------------------------------------------------------
  c_lsb_enc #(
    .P_W   (P_W),
    .IDX_W (IDX_W)
  ) u_enc (
    .i_vec   (i_is_unary),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  // Priority: all_set, then every bit at the admit value, then the first
  // position the chain flagged as a legal run end.
  always_comb begin
    w_res.len = '0;
    w_res.ok  = 1'b0;
    if (i_all_set) begin
      w_res.ok  = 1'b1;
    end else if (i_x == {P_W{ADMIT}}) begin
      w_res.len = LEN_W'(P_W);
      w_res.ok  = 1'b1;
    end else if (w_found) begin
      w_res.len = LEN_W'(w_idx);
      w_res.ok  = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Handshake and 2-entry FIFO
  // -------------------------------------------------------------------------
  assign o_vld  = (r_occ != EMPTY);
  assign o_rdy  = (r_occ != FULL) | ((r_occ == FULL) & i_rdy);
  assign w_push = i_vld & o_rdy;
  assign w_pop  = o_vld & i_rdy;

  assign o_len     = r_mem[r_rd_ptr].len;
  assign o_ok      = r_mem[r_rd_ptr].ok;
  assign o_dbg_occ = r_occ;

  // When full, a push only happens alongside a pop, so writing the slot
  // under the read pointer replaces an entry that is leaving this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_res;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ <= EMPTY;
    end else begin
      case (r_occ)
        EMPTY: if (w_push) r_occ <= ONE;
        ONE: begin
          if (w_push && !w_pop)      r_occ <= FULL;
          else if (w_pop && !w_push) r_occ <= EMPTY;
        end
        FULL: if (w_pop && !w_push) r_occ <= ONE;
        default: r_occ <= EMPTY;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Statistics, counted as results leave the buffer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || i_clr_cnt) begin
      r_ok_cnt  <= '0;
      r_err_cnt <= '0;
    end else if (w_pop) begin
      if (o_ok) begin
        if (r_ok_cnt != {P_CNT_W{1'b1}}) r_ok_cnt <= r_ok_cnt + 1'b1;
      end else begin
        if (r_err_cnt != {P_CNT_W{1'b1}}) r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign o_ok_cnt  = r_ok_cnt;
  assign o_err_cnt = r_err_cnt;

endmodule
